// File: rtl/mdu.sv
// mdu: multiply/divide unit with architectural HI/LO registers.
//
// Multiplies and divides capture their operands on issue, hold busy for a
// fixed number of cycles timed by a down-counter, and write HI/LO on the
// edge that takes the FSM back to idle. mthi/mtlo write HI/LO directly on
// issue; mfhi/mflo read them combinationally through rdata.
//
// Build option: define MDU_DIV_EN to include div/divu. Without it the DIV
// state and divider are absent and funct 011010/011011 decode as no-ops.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   isR    in   instruction is R-type
//   en     in   instruction valid and allowed to issue
//   funct  in   R-type function field
//   a, b   in   rs / rt operands
//   ismd   out  recognised MDU funct present (isR=1)
//   busy   out  multiply or divide in progress
//   stall  out  pipeline must hold the current MDU instruction
//   rdata  out  HI for mfhi, LO for mflo, zero otherwise
//   hi, lo out  architectural HI and LO
//
// state  | meaning
// S_IDLE | no operation in flight; instructions may issue
// S_MUL  | mult/multu counting down; HI/LO written at terminal count
// S_DIV  | div/divu counting down; HI/LO written at terminal count

module mdu #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             isR,
   input  logic             en,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ismd,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] rdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   localparam logic [5:0] MUL_LOAD = 6'(MULT_CYCLES);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);

`ifdef MDU_DIV_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1} state_t;
`endif

   state_t           state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             sgn_q, sgn_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

   logic f_mult, f_multu, f_div, f_divu, f_mfhi, f_mthi, f_mflo, f_mtlo;
   logic issue, start_long;

   logic [2*WIDTH-1:0] ext_a, ext_b, prod;
   logic [WIDTH-1:0]   res_hi, res_lo;

   always_comb begin
      f_mult  = (funct == F_MULT);
      f_multu = (funct == F_MULTU);
      f_mfhi  = (funct == F_MFHI);
      f_mthi  = (funct == F_MTHI);
      f_mflo  = (funct == F_MFLO);
      f_mtlo  = (funct == F_MTLO);
`ifdef MDU_DIV_EN
      f_div   = (funct == F_DIV);
      f_divu  = (funct == F_DIVU);
`else
      f_div   = 1'b0;
      f_divu  = 1'b0;
`endif
      ismd  = isR & (f_mult | f_multu | f_div | f_divu | f_mfhi | f_mthi | f_mflo | f_mtlo);
      busy  = (state_q != S_IDLE);
      stall = en & ismd & busy;
      issue = en & ismd & ~busy;
      start_long = issue & (f_mult | f_multu | f_div | f_divu);
      if (isR & f_mfhi)
         rdata = hi_q;
      else if (isR & f_mflo)
         rdata = lo_q;
      else
         rdata = '0;
   end

   // Zero- or sign-extend to 2*WIDTH; the low 2*WIDTH bits of the product
   // are then correct for both signed and unsigned operands.
   always_comb begin
      ext_a  = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
      ext_b  = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
      prod   = ext_a * ext_b;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
   end

`ifdef MDU_DIV_EN
   logic             neg_a, neg_b;
   logic [WIDTH-1:0] mag_a, mag_b, uq, ur, quo, rem;

   // Divide on magnitudes and restore signs. The most negative dividend has
   // magnitude 2^(WIDTH-1), which still fits unsigned, so MIN / -1 falls out
   // as quotient MIN, remainder 0 without a special case.
   always_comb begin
      neg_a = sgn_q & a_q[WIDTH-1];
      neg_b = sgn_q & b_q[WIDTH-1];
      mag_a = neg_a ? -a_q : a_q;
      mag_b = neg_b ? -b_q : b_q;
      uq    = '0;
      ur    = '0;
      if (b_q == '0) begin
         quo = '1;
         rem = a_q;
      end else begin
         uq  = mag_a / mag_b;
         ur  = mag_a % mag_b;
         quo = (neg_a ^ neg_b) ? -uq : uq;
         rem = neg_a ? -ur : ur;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start_long) begin
               a_d     = a;
               b_d     = b;
               sgn_d   = f_mult | f_div;
               cnt_d   = (f_mult | f_multu) ? MUL_LOAD : DIV_LOAD;
               state_d = (f_mult | f_multu) ? S_MUL : state_t'(2'd2);
            end
            if (issue & f_mthi) hi_d = a;
            if (issue & f_mtlo) lo_d = a;
         end
         default: begin
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               state_d = S_IDLE;
`ifdef MDU_DIV_EN
               if (state_q == S_DIV) begin
                  hi_d = rem;
                  lo_d = quo;
               end else begin
                  hi_d = res_hi;
                  lo_d = res_lo;
               end
`else
               hi_d = res_hi;
               lo_d = res_lo;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        isR = 1'b0;
   logic        en = 1'b0;
   logic [5:0]  funct = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        ismd, busy, stall;
   logic [31:0] rdata, hi, lo;

   mdu #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .rst_n(rst_n), .isR(isR), .en(en), .funct(funct),
      .a(a), .b(b), .ismd(ismd), .busy(busy), .stall(stall),
      .rdata(rdata), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit cmp_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mthi, 7 mflo, 8 mtlo
   function automatic int kind(input logic [5:0] f);
      case (f)
         F_MULT:  return 1;
         F_MULTU: return 2;
`ifdef MDU_DIV_EN
         F_DIV:   return 3;
         F_DIVU:  return 4;
`endif
         F_MFHI:  return 5;
         F_MTHI:  return 6;
         F_MFLO:  return 7;
         F_MTLO:  return 8;
         default: return 0;
      endcase
   endfunction

   // Reference model: pending result plus remaining busy cycles.
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   int          m_rem = 0;
   longint      sp;
   logic [63:0] up;
   int          sa, sb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hi = '0; m_lo = '0; m_rem = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else if (en && isR) begin
         case (kind(funct))
            1: begin
               sp = longint'($signed(a)) * longint'($signed(b));
               up = 64'(sp);
               p_hi = up[63:32]; p_lo = up[31:0]; m_rem = MC;
            end
            2: begin
               up = {32'b0, a} * {32'b0, b};
               p_hi = up[63:32]; p_lo = up[31:0]; m_rem = MC;
            end
            3: begin
               if (b == 0) begin
                  p_hi = a; p_lo = 32'hFFFFFFFF;
               end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                  p_hi = 0; p_lo = 32'h80000000;
               end else begin
                  sa = a; sb = b;
                  p_lo = 32'(sa / sb); p_hi = 32'(sa % sb);
               end
               m_rem = DC;
            end
            4: begin
               if (b == 0) begin
                  p_hi = a; p_lo = 32'hFFFFFFFF;
               end else begin
                  p_lo = a / b; p_hi = a % b;
               end
               m_rem = DC;
            end
            6: m_hi = a;
            8: m_lo = a;
            default: ;
         endcase
      end
   end

   int          ck;
   logic        e_ismd;
   logic [31:0] e_rdata;

   always @(negedge clk) begin
      if (cmp_on) begin
         ck = kind(funct);
         e_ismd = isR && (ck != 0);
         e_rdata = (isR && ck == 5) ? m_hi : (isR && ck == 7) ? m_lo : 32'h0;
         chk("ismd", 32'(ismd), 32'(e_ismd));
         chk("busy", 32'(busy), 32'(m_rem > 0));
         chk("stall", 32'(stall), 32'(en && e_ismd && (m_rem > 0)));
         chk("rdata", rdata, e_rdata);
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
      end
   end

   task automatic drive(input logic r, input logic e, input logic [5:0] f,
                        input logic [31:0] aa, input logic [31:0] bb);
      @(posedge clk);
      #1;
      isR = r; en = e; funct = f; a = aa; b = bb;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) n++;
         else if (n > 0 || i > 2) break;
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] c [6];
      c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFFFFFF;
      c[3] = 32'h80000000; c[4] = 32'h7FFFFFFF; c[5] = 32'h2;
      if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   int n;
   logic [5:0] ftab [8];

   initial begin
      ftab[0] = F_MULT; ftab[1] = F_MULTU; ftab[2] = F_DIV; ftab[3] = F_DIVU;
      ftab[4] = F_MFHI; ftab[5] = F_MTHI; ftab[6] = F_MFLO; ftab[7] = F_MTLO;

      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      cmp_on = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // multu 0xFFFFFFFF * 2
      drive(1'b1, 1'b1, F_MULTU, 32'hFFFFFFFF, 32'd2);
      idle();
      count_busy(n);
      chk("multu_busy_cycles", 32'(n), 32'd5);
      chk("multu_hi", hi, 32'h00000001);
      chk("multu_lo", lo, 32'hFFFFFFFE);

      // mult -2 * 3
      drive(1'b1, 1'b1, F_MULT, 32'hFFFFFFFE, 32'd3);
      idle();
      count_busy(n);
      chk("mult_busy_cycles", 32'(n), 32'd5);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFFA);

`ifdef MDU_DIV_EN
      drive(1'b1, 1'b1, F_DIV, 32'hFFFFFFF9, 32'd2);
      idle();
      count_busy(n);
      chk("div_busy_cycles", 32'(n), 32'd10);
      chk("div_lo", lo, 32'hFFFFFFFD);
      chk("div_hi", hi, 32'hFFFFFFFF);
      drive(1'b1, 1'b1, F_DIV, 32'hFFFFFFF9, 32'd0);
      idle();
      count_busy(n);
      chk("div0_hi", hi, 32'hFFFFFFF9);
      chk("div0_lo", lo, 32'hFFFFFFFF);
      drive(1'b1, 1'b1, F_DIV, 32'h80000000, 32'hFFFFFFFF);
      idle();
      count_busy(n);
      chk("divovf_lo", lo, 32'h80000000);
      chk("divovf_hi", hi, 32'h0);
      drive(1'b1, 1'b1, F_DIVU, 32'h0000002A, 32'd0);
      idle();
      count_busy(n);
      chk("divu0_hi", hi, 32'h0000002A);
      chk("divu0_lo", lo, 32'hFFFFFFFF);
      drive(1'b1, 1'b1, F_MULT, 32'hFFFFFFFE, 32'd3);
      idle();
      count_busy(n);
`endif

      // mflo held from the cycle after mult issue
      drive(1'b1, 1'b1, F_MULT, 32'hFFFFFFF0, 32'd3);
      drive(1'b1, 1'b1, F_MFLO, 32'd0, 32'd0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         chk("mflo_stall", 32'(stall), 32'h1);
      end
      chk("mflo_stall_cycles", 32'(n), 32'd5);
      chk("mflo_rdata", rdata, 32'hFFFFFFD0);
      chk("mflo_stall_end", 32'(stall), 32'h0);
      idle();

      // reset in busy cycle 3 of a mult
      drive(1'b1, 1'b1, F_MULT, 32'd3, 32'd4);
      idle();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(busy), 32'h0);
      chk("rst_mid_hi", hi, 32'h0);
      chk("rst_mid_lo", lo, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b1, F_MTHI, 32'h12345678, 32'd0);
      idle();
      chk("mthi_after_rst", hi, 32'h12345678);
      chk("mthi_no_busy", 32'(busy), 32'h0);

`ifndef MDU_DIV_EN
      drive(1'b1, 1'b1, F_DIVU, 32'd5, 32'd1);
      @(negedge clk);
      chk("nodiv_ismd", 32'(ismd), 32'h0);
      chk("nodiv_stall", 32'(stall), 32'h0);
      idle();
      @(negedge clk);
      chk("nodiv_busy", 32'(busy), 32'h0);
      chk("nodiv_hi", hi, 32'h12345678);
`endif

      for (int i = 0; i < 500; i++) begin
         logic [5:0] f;
         if ($urandom_range(0, 4) == 0) f = 6'($urandom);
         else f = ftab[$urandom_range(0, 7)];
         drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0), f, pick(), pick());
      end
      idle();
      repeat (15) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width in bits.
REQ-002 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu (range 1..63).
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for div/divu (range 1..63).
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1: asynchronous, active-low reset.
REQ-006 isR  in  1: the current instruction is R-type (opcode 000000).
REQ-007 en  in  1: the instruction is valid and allowed to issue this cycle.
REQ-008 funct  in  6: R-type function field.
REQ-009 a  in  WIDTH: rs operand.
REQ-010 b  in  WIDTH: rt operand.
REQ-011 ismd  out  1: a recognised MDU funct is present (isR=1); independent of en.
REQ-012 busy  out  1: a multiply or divide is in progress.
REQ-013 stall  out  1: the pipeline holds the current MDU instruction.
REQ-014 rdata  out  WIDTH: HI for mfhi, LO for mflo, zero otherwise.
REQ-015 hi, lo  out  WIDTH each: architectural HI and LO registers.

Function
REQ-016 Decode: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011; any other funct, or isR=0, is a no-op with ismd=0.
REQ-017 Issue: an instruction issues only when en=1, isR=1, ismd=1 and stall=0.
REQ-018 stall = en & isR & ismd & busy; mfhi/mflo/mthi/mtlo also stall while busy.
REQ-019 FSM states: IDLE, MUL, DIV. Transitions: IDLE->MUL on issue of mult/multu; IDLE->DIV on issue of div/divu; MUL/DIV->IDLE when the counter reaches 1.
REQ-020 On issue of mult/multu/div/divu, capture a and b and load the counter with MULT_CYCLES or DIV_CYCLES respectively; busy goes to 1 on the following cycle.
REQ-021 busy=1 exactly in the MUL and DIV states, for exactly the configured number of cycles.
REQ-022 The counter decrements by 1 per cycle while busy=1.
REQ-023 HI/LO are written on the edge that returns the FSM to IDLE; a back-to-back MDU instruction can issue in the first cycle with busy=0.
REQ-024 mult: signed 2*WIDTH product; multu: unsigned; HI takes the upper half, LO the lower half.
REQ-025 div/divu: LO = quotient, HI = remainder; signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-026 Divide by zero: HI = captured a, LO = all ones; applies to both div and divu.
REQ-027 div of the most negative value by -1: LO = most negative value, HI = 0.
REQ-028 mthi/mtlo: write a to HI/LO on the issuing edge; no busy cycles.
REQ-029 mfhi/mflo: rdata is combinational from the current HI/LO; no state change.
REQ-030 A non-issued instruction (en=0, or stall=1) causes no state change.

Reset
REQ-031 rst_n=0 SHALL immediately force: FSM=IDLE, counter=0, busy=0, hi=0, lo=0, captured operands=0.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no HI/LO update; after release, the FSM is in IDLE.
REQ-033 The reset release is synchronised by the instantiating logic; the block SHALL first act on the first rising edge with rst_n=1.

Configuration
REQ-034 Macro MDU_DIV_EN defined: div/divu are supported exactly as specified above.
REQ-035 MDU_DIV_EN undefined: the DIV state and divider logic are absent; funct 011010/011011 decode as no-ops (ismd=0, no stall, HI/LO unchanged).

Verification
REQ-036 multu a=0xFFFFFFFF, b=2 -> busy=1 for 5 cycles; then hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 mult a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-038 div a=0xFFFFFFF9 (-7), b=2 -> busy=1 for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. With b=0: hi=0xFFFFFFF9, lo=0xFFFFFFFF.
REQ-039 mflo presented with en=1 in the cycle after mult issue -> stall=1 until busy=0; rdata then equals the new lo.
REQ-040 Start mult, drive rst_n=0 for 1 cycle at busy cycle 3 -> busy=0 immediately, hi=lo=0; a following mthi a=0x12345678 -> hi=0x12345678 on the next edge.
REQ-041 Build without MDU_DIV_EN, issue divu -> ismd=0, stall=0, busy stays 0, HI/LO unchanged.
